fifo_mc_sync: RTL and testbench

- Parametrised multi-channel synchronous FIFO; successor to the single-channel dual-clock FIFO top in the afifo verification environment.
- Holds CH independent FIFOs on one clock, one write port per channel and a shared read port with channel select.
- Per channel: full, empty, almost-full, almost-empty, occupancy, sticky overflow/underflow and synchronous flush.
- Sits between multi-source producers and a single arbitrated consumer.

---
 rtl/fifo_mc_sync_if.sv | 38 +++
 rtl/fifo_mc_sync.sv | 137 +++++++++++++
 tb/tb_fifo_mc_sync.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mc_sync_if.sv
// Handshake bundle for the multi-channel synchronous FIFO.
// The master side is the producer/consumer. The slave side is the FIFO itself.
interface fifo_mc_sync_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CH    = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CH);

    logic [CH-1:0]        wr_en;
    logic [CH*DW-1:0]     wr_data;
    logic                 rd_en;
    logic [CW-1:0]        rd_ch;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic [CH-1:0]        flush;
    logic [CH-1:0]        full;
    logic [CH-1:0]        empty;
    logic [CH-1:0]        almost_full;
    logic [CH-1:0]        almost_empty;
    logic [CH*(AW+1)-1:0] count;
    logic [CH-1:0]        ovf;
    logic [CH-1:0]        udf;
    logic                 err_clr;

    modport master (
        output wr_en, wr_data, rd_en, rd_ch, flush, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en, rd_ch, flush, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, ovf, udf
    );
endinterface

// File: rtl/fifo_mc_sync.sv
// Multi-channel synchronous FIFO. There are CH independent queues on one clock.
// Each channel has its own write port. All channels share one read port, and
// rd_ch selects the channel. Each channel reports full, empty and
// almost-full/almost-empty flags, its occupancy, sticky error bits and a flush.
// Optional macro FIFO_MC_FWFT_EN switches the read port to first-word
// fall-through. By default a read returns its data on the next cycle from a register.
module fifo_mc_sync #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int CH    = 4,
    parameter int AF_TH = 14,
    parameter int AE_TH = 2
) (
    input  logic          clk,
    input  logic          arst_n,
    fifo_mc_sync_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CH);

    logic [DW-1:0] mem [CH][DEPTH];
    logic [AW:0]   wptr [CH];
    logic [AW:0]   rptr [CH];
    logic [AW:0]   cnt  [CH];

    logic [CH-1:0] full_w, empty_w;
    logic [CH-1:0] rd_hit, wr_acc, ovf_set, udf_set;
    logic [CH-1:0] ovf_q, udf_q;
    logic          rd_acc;
    logic          sel_empty, sel_flush;
    logic [DW-1:0] sel_data;

    // Status flags come straight from the registered occupancy.
    for (genvar g = 0; g < CH; g++) begin : g_flags
        assign full_w[g]       = (cnt[g] == (AW+1)'(DEPTH));
        assign empty_w[g]      = (cnt[g] == '0);
        assign bus.almost_full[g]  = (cnt[g] >= (AW+1)'(AF_TH));
        assign bus.almost_empty[g] = (cnt[g] <= (AW+1)'(AE_TH));
        assign bus.count[g*(AW+1) +: AW+1] = cnt[g];
    end

    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

    // Read-channel select, read and write acceptance, and error events for each channel.
    // A flush cancels any read or write to its own channel in the same cycle.
    always_comb begin
        sel_empty = 1'b1;
        sel_flush = 1'b0;
        sel_data  = '0;
        rd_hit    = '0;
        udf_set   = '0;
        wr_acc    = '0;
        ovf_set   = '0;
        for (int i = 0; i < CH; i++) begin
            if (bus.rd_ch == CW'(i)) begin
                sel_empty = empty_w[i];
                sel_flush = bus.flush[i];
                sel_data  = mem[i][rptr[i][AW-1:0]];
            end
        end
        rd_acc = bus.rd_en && !sel_empty && !sel_flush;
        for (int i = 0; i < CH; i++) begin
            rd_hit[i]  = rd_acc && (bus.rd_ch == CW'(i));
            udf_set[i] = bus.rd_en && (bus.rd_ch == CW'(i)) && empty_w[i] && !bus.flush[i];
            wr_acc[i]  = bus.wr_en[i] && !bus.flush[i] && (!full_w[i] || rd_hit[i]);
            ovf_set[i] = bus.wr_en[i] && !bus.flush[i] && full_w[i] && !rd_hit[i];
        end
    end

    // Storage array. Its contents are not reset. A write to a full channel with a
    // same-cycle read reuses the slot that is being read out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (wr_acc[i]) mem[i][wptr[i][AW-1:0]] <= bus.wr_data[i*DW +: DW];
        end
    end

    // Pointers and occupancy for each channel. A flush returns the channel to empty.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < CH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (bus.flush[i]) begin
                    wptr[i] <= '0;
                    rptr[i] <= '0;
                    cnt[i]  <= '0;
                end else begin
                    if (wr_acc[i]) wptr[i] <= wptr[i] + 1'b1;
                    if (rd_hit[i]) rptr[i] <= rptr[i] + 1'b1;
                    if (wr_acc[i] && !rd_hit[i]) cnt[i] <= cnt[i] + 1'b1;
                    else if (!wr_acc[i] && rd_hit[i]) cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Sticky error bits. A new event in the same cycle as err_clr keeps its bit set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_set | (bus.err_clr ? '0 : ovf_q);
            udf_q <= udf_set | (bus.err_clr ? '0 : udf_q);
        end
    end

`ifdef FIFO_MC_FWFT_EN
    assign bus.rd_data  = sel_data;
    assign bus.rd_valid = !sel_empty;
`else
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;

    // Registered read port. The data holds between reads, and valid pulses once for each accepted read.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= sel_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_fifo_mc_sync.sv
// Testbench for fifo_mc_sync. It runs directed scenarios and then randomized
// traffic. A queue-based model in the bench is compared against the DUT on every cycle.
module tb_fifo_mc_sync;
    logic clk = 1'b0;
    logic arst_n = 1'b0;

    fifo_mc_sync_if #(.DW(8), .DEPTH(16), .CH(4)) bus ();

    fifo_mc_sync #(.DW(8), .DEPTH(16), .CH(4), .AF_TH(14), .AE_TH(2)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;

    logic [7:0] mq [4][$];
    logic [3:0] m_ovf = '0, m_udf = '0, ovf_set, udf_set, rd_hit;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;

    logic [3:0]  r_we, r_fl;
    logic [31:0] r_wd;
    logic        r_re, r_ec;
    logic [1:0]  r_rc;
    int          wp, rp;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] we, input logic [31:0] wd, input logic re,
                                  input logic [1:0] rc, input logic [3:0] fl, input logic ec);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_ch   = rc;
        bus.flush   = fl;
        bus.err_clr = ec;
    endtask

    task automatic idle(input logic [1:0] rc);
        apply_stimulus(4'b0, 32'b0, 1'b0, rc, 4'b0, 1'b0);
    endtask

    task automatic write_word(input int ch, input logic [7:0] val);
        apply_stimulus(4'b1 << ch, {24'b0, val} << (ch * 8), 1'b0, 2'd0, 4'b0, 1'b0);
    endtask

    task automatic read_word(input logic [1:0] ch, input logic [7:0] exp);
`ifdef FIFO_MC_FWFT_EN
        idle(ch);
        #1;
        check_output("fwft_rd_valid", 32'(bus.rd_valid), 32'd1);
        check_output("fwft_rd_data", 32'(bus.rd_data), 32'(exp));
        apply_stimulus(4'b0, 32'b0, 1'b1, ch, 4'b0, 1'b0);
`else
        apply_stimulus(4'b0, 32'b0, 1'b1, ch, 4'b0, 1'b0);
        idle(ch);
        check_output("rd_valid", 32'(bus.rd_valid), 32'd1);
        check_output("rd_data", 32'(bus.rd_data), 32'(exp));
`endif
    endtask

    function automatic logic [4:0] dut_count(input int c);
        return bus.count[c*5 +: 5];
    endfunction

    // Reference model: each channel is a plain queue, updated at each clock edge from the driven inputs.
    initial forever begin
        @(posedge clk or negedge arst_n);
        if (!arst_n) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            m_ovf = '0; m_udf = '0; m_valid = 1'b0; m_data = '0;
        end else begin
            ovf_set = '0; udf_set = '0; rd_hit = '0;
            m_valid = 1'b0;
            if (bus.rd_en && !bus.flush[bus.rd_ch]) begin
                if (mq[bus.rd_ch].size() > 0) begin
                    m_data  = mq[bus.rd_ch].pop_front();
                    m_valid = 1'b1;
                    rd_hit[bus.rd_ch] = 1'b1;
                end else begin
                    udf_set[bus.rd_ch] = 1'b1;
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (bus.flush[c]) mq[c].delete();
                else if (bus.wr_en[c]) begin
                    if (mq[c].size() < 16 || rd_hit[c]) mq[c].push_back(bus.wr_data[c*8 +: 8]);
                    else ovf_set[c] = 1'b1;
                end
            end
            m_ovf = ovf_set | (bus.err_clr ? 4'b0 : m_ovf);
            m_udf = udf_set | (bus.err_clr ? 4'b0 : m_udf);
        end
    end

    // Compare DUT outputs against the model one time unit after every rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            check_output($sformatf("count[%0d]", c), 32'(dut_count(c)), mq[c].size());
            check_output($sformatf("full[%0d]", c), 32'(bus.full[c]), 32'(mq[c].size() == 16));
            check_output($sformatf("empty[%0d]", c), 32'(bus.empty[c]), 32'(mq[c].size() == 0));
            check_output($sformatf("almost_full[%0d]", c), 32'(bus.almost_full[c]), 32'(mq[c].size() >= 14));
            check_output($sformatf("almost_empty[%0d]", c), 32'(bus.almost_empty[c]), 32'(mq[c].size() <= 2));
        end
        check_output("ovf", 32'(bus.ovf), 32'(m_ovf));
        check_output("udf", 32'(bus.udf), 32'(m_udf));
`ifdef FIFO_MC_FWFT_EN
        check_output("rd_valid", 32'(bus.rd_valid), 32'(mq[bus.rd_ch].size() > 0));
        if (mq[bus.rd_ch].size() > 0) check_output("rd_data", 32'(bus.rd_data), 32'(mq[bus.rd_ch][0]));
`else
        check_output("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        check_output("rd_data", 32'(bus.rd_data), 32'(m_data));
`endif
    end

    // Directed scenarios first, then randomized traffic with one reset in the middle.
    initial begin
        bus.wr_en = '0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.rd_ch = '0;
        bus.flush = '0; bus.err_clr = 1'b0;
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        idle(2'd0);
        check_output("reset_empty", 32'(bus.empty), 32'hF);
        check_output("reset_almost_empty", 32'(bus.almost_empty), 32'hF);
        check_output("reset_count", 32'(bus.count), 32'h0);
        check_output("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_output("reset_full", 32'(bus.full), 32'h0);

`ifdef FIFO_MC_FWFT_EN
        write_word(0, 8'h33);
        idle(2'd0);
        #1;
        check_output("fwft_head_valid", 32'(bus.rd_valid), 32'd1);
        check_output("fwft_head_data", 32'(bus.rd_data), 32'h33);
        read_word(2'd0, 8'h33);
        idle(2'd0);
`endif

        for (int n = 1; n <= 16; n++) begin
            write_word(2, 8'(n));
            idle(2'd2);
            check_output("ch2_almost_full", 32'(bus.almost_full[2]), 32'(n >= 14));
        end
        check_output("ch2_full", 32'(bus.full[2]), 32'd1);
        check_output("ch2_count16", 32'(dut_count(2)), 32'd16);
        for (int n = 1; n <= 16; n++) read_word(2'd2, 8'(n));
        idle(2'd2);
        check_output("ch2_empty_end", 32'(bus.empty[2]), 32'd1);

        for (int n = 0; n < 16; n++) write_word(1, 8'(8'h20 + n));
        write_word(1, 8'hEE);
        idle(2'd1);
        check_output("ch1_ovf", 32'(bus.ovf[1]), 32'd1);
        check_output("ch1_count_after_ovf", 32'(dut_count(1)), 32'd16);
        apply_stimulus(4'b0, 32'b0, 1'b0, 2'd1, 4'b0, 1'b1);
        idle(2'd1);
        check_output("ovf_cleared", 32'(bus.ovf), 32'd0);
        for (int n = 0; n < 16; n++) read_word(2'd1, 8'(8'h20 + n));

        for (int n = 0; n < 16; n++) write_word(0, 8'(8'h40 + n));
        apply_stimulus(4'b0001, 32'h0000_00AA, 1'b1, 2'd0, 4'b0, 1'b0);
        idle(2'd0);
        check_output("ch0_count_rw_full", 32'(dut_count(0)), 32'd16);
        for (int n = 0; n < 15; n++) read_word(2'd0, 8'(8'h41 + n));
        read_word(2'd0, 8'hAA);

        apply_stimulus(4'b1000, 32'h5500_0000, 1'b1, 2'd3, 4'b0, 1'b0);
        idle(2'd3);
        check_output("ch3_udf", 32'(bus.udf[3]), 32'd1);
`ifndef FIFO_MC_FWFT_EN
        check_output("ch3_no_valid", 32'(bus.rd_valid), 32'd0);
`endif
        check_output("ch3_count1", 32'(dut_count(3)), 32'd1);
        read_word(2'd3, 8'h55);

        for (int n = 0; n < 5; n++) write_word(1, 8'(8'h60 + n));
        write_word(0, 8'h71);
        write_word(0, 8'h72);
        apply_stimulus(4'b0010, 32'h0000_9900, 1'b0, 2'd0, 4'b0010, 1'b0);
        idle(2'd0);
        check_output("ch1_flushed_count", 32'(dut_count(1)), 32'd0);
        check_output("ch1_flushed_empty", 32'(bus.empty[1]), 32'd1);
        check_output("ch0_untouched", 32'(dut_count(0)), 32'd2);
        check_output("ch2_untouched", 32'(dut_count(2)), 32'd0);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                @(negedge clk);
                arst_n = 1'b0;
                #1;
                check_output("midreset_rd_valid", 32'(bus.rd_valid), 32'd0);
                check_output("midreset_count", 32'(bus.count), 32'd0);
                repeat (2) @(negedge clk);
                arst_n = 1'b1;
            end
            wp = ((cyc / 250) % 2 == 0) ? 70 : 20;
            rp = ((cyc / 250) % 2 == 0) ? 30 : 85;
            for (int c = 0; c < 4; c++) begin
                r_we[c] = ($urandom_range(99) < wp);
                r_fl[c] = ($urandom_range(59) == 0);
            end
            r_wd = $urandom;
            r_re = ($urandom_range(99) < rp);
            r_rc = 2'($urandom_range(3));
            r_ec = ($urandom_range(15) == 0);
            apply_stimulus(r_we, r_wd, r_re, r_rc, r_fl, r_ec);
        end
        idle(2'd0);
        idle(2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
